// File: rtl/card_dealer.sv
// Single-deck card dealer: arbitrates player/dealer requests and deals
// cards without replacement, using a free-running counter as the draw.
module card_dealer #(
    parameter int DECK_SIZE = 52,
    parameter int IDX_W     = 6
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_shuffle,
    input  logic             i_req_player,
    input  logic             i_req_dealer,
    output logic             o_grant_player,
    output logic             o_grant_dealer,
    output logic             o_card_valid,
    output logic [IDX_W-1:0] o_card_index,
    output logic [3:0]       o_card_rank,
    output logic [1:0]       o_card_suit,
    output logic [IDX_W-1:0] o_cards_left,
    output logic             o_deck_empty,
    output logic             o_busy
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_PROBE   = 2'd1;
    localparam logic [1:0] S_DELIVER = 2'd2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DECK_SIZE - 1);
    localparam logic [IDX_W-1:0] FULL     = IDX_W'(DECK_SIZE);
    localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);
    localparam logic [IDX_W-1:0] THIRTEEN = IDX_W'(13);

    logic [1:0]           state;
    logic [IDX_W-1:0]     rnd;
    logic [IDX_W-1:0]     probe;
    logic [IDX_W-1:0]     cards_left;
    logic [DECK_SIZE-1:0] used;
    logic                 last_dealer;
    logic                 win_dealer;
    logic                 pick_dealer;
    logic                 any_req;

    // Returns {suit, rank}; repeated subtraction avoids a divider.
    function automatic logic [5:0] card_of(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] r;
        logic [2:0]       q;
        r = idx;
        q = 3'd0;
        for (int k = 0; k < 4; k++) begin
            if (r >= THIRTEEN) begin
                r = r - THIRTEEN;
                q = q + 3'd1;
            end
        end
        return {q[1:0], 4'(r) + 4'd1};
    endfunction

    assign any_req = i_req_player | i_req_dealer;

    always_comb begin
        pick_dealer = i_req_dealer;
        if (i_req_player && i_req_dealer) begin
            pick_dealer = !last_dealer;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rnd <= '0;
        end else if (rnd == LAST_IDX) begin
            rnd <= '0;
        end else begin
            rnd <= rnd + ONE;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state        <= S_IDLE;
            probe        <= '0;
            cards_left   <= FULL;
            used         <= '0;
            last_dealer  <= 1'b1;
            win_dealer   <= 1'b0;
            o_card_index <= '0;
            o_card_rank  <= '0;
            o_card_suit  <= '0;
        end else begin
            if (i_shuffle) begin
                used       <= '0;
                cards_left <= FULL;
            end
            case (state)
                S_IDLE: begin
                    if (!i_shuffle && any_req && cards_left != '0) begin
                        win_dealer <= pick_dealer;
                        probe      <= rnd;
                        state      <= S_PROBE;
                    end
                end
                S_PROBE: begin
                    if (i_shuffle) begin
                        state <= S_IDLE;
                    end else if (!used[probe]) begin
                        used[probe]  <= 1'b1;
                        cards_left   <= cards_left - ONE;
                        o_card_index <= probe;
                        {o_card_suit, o_card_rank} <= card_of(probe);
                        state        <= S_DELIVER;
                    end else if (probe == LAST_IDX) begin
                        probe <= '0;
                    end else begin
                        probe <= probe + ONE;
                    end
                end
                S_DELIVER: begin
                    // A shuffle here already cleared the mask above,
                    // so the delivered card goes back into the deck.
                    last_dealer <= win_dealer;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_card_valid   = (state == S_DELIVER);
    assign o_grant_player = o_card_valid && !win_dealer;
    assign o_grant_dealer = o_card_valid && win_dealer;
    assign o_cards_left   = cards_left;
    assign o_deck_empty   = (cards_left == '0);
    assign o_busy         = (state == S_PROBE) || (state == S_DELIVER);

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer: vector table, scoreboard queue
// and hand-written abort / arbitration / exhaustion sequences.
module tb_card_dealer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       shuffle = 1'b0;
    logic       req_p = 1'b0;
    logic       req_d = 1'b0;
    logic       gnt_p, gnt_d, valid, empty, busy;
    logic [5:0] idx, left;
    logic [3:0] rank;
    logic [1:0] suit;

    int total = 0;
    int bad = 0;

    logic [5:0] rnd_m;

    typedef struct {
        logic       gd;
        logic       chk;
        logic [5:0] idx;
        logic [3:0] rank;
        logic [1:0] suit;
        logic [5:0] left;
    } exp_t;

    typedef struct {
        logic       gd;
        int         r;
        int         extra;
        logic [5:0] idx;
        logic [3:0] rank;
        logic [1:0] suit;
        logic [5:0] left;
    } vec_t;

    exp_t sbq[$];
    exp_t mon_e;
    vec_t vt[8];

    card_dealer #(.DECK_SIZE(52), .IDX_W(6)) dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_shuffle      (shuffle),
        .i_req_player   (req_p),
        .i_req_dealer   (req_d),
        .o_grant_player (gnt_p),
        .o_grant_dealer (gnt_d),
        .o_card_valid   (valid),
        .o_card_index   (idx),
        .o_card_rank    (rank),
        .o_card_suit    (suit),
        .o_cards_left   (left),
        .o_deck_empty   (empty),
        .o_busy         (busy)
    );

    always #5 clk = ~clk;

    // Expected draw counter: 0..51, running from reset release.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rnd_m <= 6'd0;
        else rnd_m <= (rnd_m == 6'd51) ? 6'd0 : rnd_m + 6'd1;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (valid || gnt_p || gnt_d)) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_grant: valid=%0b gp=%0b gd=%0b expected none",
                         valid, gnt_p, gnt_d);
            end else begin
                mon_e = sbq.pop_front();
                check("sb_valid", valid, 1);
                check("sb_grant_player", gnt_p, !mon_e.gd);
                check("sb_grant_dealer", gnt_d, mon_e.gd);
                if (mon_e.chk) begin
                    check("sb_index", idx, mon_e.idx);
                    check("sb_rank", rank, mon_e.rank);
                    check("sb_suit", suit, mon_e.suit);
                end
                check("sb_cards_left", left, mon_e.left);
                check("sb_deck_empty", empty, mon_e.left == 6'd0);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant_player"}, gnt_p, 0);
        check({tag, "_grant_dealer"}, gnt_d, 0);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_index"}, idx, 0);
        check({tag, "_rank"}, rank, 0);
        check({tag, "_suit"}, suit, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_empty"}, empty, 0);
        check({tag, "_left"}, left, 52);
    endtask

    task automatic wait_rnd(input int r);
        int n;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (rnd_m != r[5:0] && n < 200);
        check("rnd_wait", rnd_m, r);
    endtask

    task automatic deal(input vec_t v, input string tag);
        exp_t e;
        int   n;
        bit   hit;
        wait_rnd(v.r);
        e = '{v.gd, 1'b1, v.idx, v.rank, v.suit, v.left};
        sbq.push_back(e);
        if (v.gd) req_d = 1'b1;
        else req_p = 1'b1;
        n = 0;
        hit = 1'b0;
        while (!hit && n < 80) begin
            @(posedge clk);
            #1;
            n++;
            hit = valid;
        end
        check({tag, "_granted"}, hit, 1);
        check({tag, "_latency"}, n, 2 + v.extra);
        req_p = 1'b0;
        req_d = 1'b0;
        @(negedge clk);
        #1;
    endtask

    initial begin
        exp_t        e;
        vec_t        v;
        int          n;
        int          cnt;
        int          stray;
        bit          hit;
        logic [63:0] seen;

        // gd, rnd, extra probes, idx, rank, suit, cards_left
        vt[0] = '{1'b0, 5,  0, 6'd5,  4'd6,  2'd0, 6'd51};
        vt[1] = '{1'b1, 5,  1, 6'd6,  4'd7,  2'd0, 6'd50};
        vt[2] = '{1'b0, 51, 0, 6'd51, 4'd13, 2'd3, 6'd49};
        vt[3] = '{1'b1, 50, 0, 6'd50, 4'd12, 2'd3, 6'd48};
        vt[4] = '{1'b0, 50, 2, 6'd0,  4'd1,  2'd0, 6'd47};
        vt[5] = '{1'b1, 20, 0, 6'd20, 4'd8,  2'd1, 6'd46};
        vt[6] = '{1'b0, 38, 0, 6'd38, 4'd13, 2'd2, 6'd45};
        vt[7] = '{1'b1, 0,  1, 6'd1,  4'd2,  2'd0, 6'd44};

        #12;
        check_reset_outputs("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_reset_outputs("after_reset");

        for (int i = 0; i < 8; i++) begin
            deal(vt[i], $sformatf("vec%0d", i));
        end

        // Shuffle while probing past dealt cards 5 and 6.
        wait_rnd(5);
        req_p = 1'b1;
        @(posedge clk);
        #1;
        check("abort_sh_busy", busy, 1);
        shuffle = 1'b1;
        @(posedge clk);
        #1;
        shuffle = 1'b0;
        req_p = 1'b0;
        check("abort_sh_idle", busy, 0);
        check("abort_sh_valid", valid, 0);
        check("abort_sh_left", left, 52);
        check("abort_sh_empty", empty, 0);
        stray = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (valid || gnt_p || gnt_d) stray++;
        end
        check("abort_sh_no_grant", stray, 0);
        v = '{1'b0, 5, 0, 6'd5, 4'd6, 2'd0, 6'd51};
        deal(v, "post_shuffle");

        // Reset while probing past dealt card 5.
        wait_rnd(5);
        req_p = 1'b1;
        @(posedge clk);
        #1;
        check("abort_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort_rst");
        req_p = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        deal(v, "post_reset");

        // Both requesters held from reset: alternate starting with player.
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req_p = 1'b1;
        req_d = 1'b1;
        e = '{1'b0, 1'b1, 6'd0, 4'd1,  2'd0, 6'd51}; sbq.push_back(e);
        e = '{1'b1, 1'b1, 6'd3, 4'd4,  2'd0, 6'd50}; sbq.push_back(e);
        e = '{1'b0, 1'b1, 6'd6, 4'd7,  2'd0, 6'd49}; sbq.push_back(e);
        e = '{1'b1, 1'b1, 6'd9, 4'd10, 2'd0, 6'd48}; sbq.push_back(e);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        n = 0;
        while (cnt < 4 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (valid) cnt++;
            check("tie_no_overlap", gnt_p && gnt_d, 0);
        end
        req_p = 1'b0;
        req_d = 1'b0;
        check("tie_grant_count", cnt, 4);

        // Exhaust the deck with a held player request.
        @(posedge clk);
        #1;
        shuffle = 1'b1;
        @(posedge clk);
        #1;
        shuffle = 1'b0;
        check("exh_start_left", left, 52);
        for (int i = 0; i < 52; i++) begin
            e = '{1'b0, 1'b0, 6'd0, 4'd0, 2'd0, 6'(51 - i)};
            sbq.push_back(e);
        end
        seen = '0;
        cnt = 0;
        n = 0;
        req_p = 1'b1;
        while (cnt < 52 && n < 4000) begin
            @(posedge clk);
            #1;
            n++;
            if (valid) begin
                check("exh_distinct", seen[idx], 0);
                check("exh_idx_range", idx < 6'd52, 1);
                seen[idx] = 1'b1;
                cnt++;
            end
        end
        check("exh_deal_count", cnt, 52);
        check("exh_left_zero", left, 0);
        check("exh_empty", empty, 1);
        stray = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (valid || gnt_p || gnt_d) stray++;
        end
        check("exh_no_grant", stray, 0);
        check("exh_idle", busy, 0);
        e = '{1'b0, 1'b0, 6'd0, 4'd0, 2'd0, 6'd51};
        sbq.push_back(e);
        shuffle = 1'b1;
        @(posedge clk);
        #1;
        shuffle = 1'b0;
        check("exh_refill_left", left, 52);
        check("exh_refill_empty", empty, 0);
        hit = 1'b0;
        n = 0;
        while (!hit && n < 80) begin
            @(posedge clk);
            #1;
            n++;
            hit = valid;
        end
        check("exh_refill_granted", hit, 1);
        req_p = 1'b0;
        @(negedge clk);
        #1;

        check("sb_drained", sbq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
